// File: rtl/line_prefetch_buffer_if.sv
// Bundle of the pixel-timing, fetch-handshake and pixel-output signals
// connecting the scanline prefetch buffer to its environment.
interface line_prefetch_buffer_if;
  logic        pixelEn;
  logic        displayActive;
  logic [8:0]  row;
  logic [9:0]  column;
  logic        rdReq;
  logic [8:0]  rdRow;
  logic        rdAck;
  logic [15:0] rdData;
  logic        rdValid;
  logic [2:0]  color;
  logic        underrun;
  logic        fetching;

  // Environment side: VGA timing plus the cell-store read port
  modport master (
    output pixelEn, displayActive, row, column, rdAck, rdData, rdValid,
    input  rdReq, rdRow, color, underrun, fetching
  );

  // Buffer side
  modport slave (
    input  pixelEn, displayActive, row, column, rdAck, rdData, rdValid,
    output rdReq, rdRow, color, underrun, fetching
  );
endinterface

// File: rtl/line_prefetch_buffer.sv
// Ping-pong scanline buffer: one bank is shown on the VGA output while the
// other is filled with the row after next from the cell store.
module line_prefetch_buffer #(
  parameter int         H_ACTIVE = 640,
  parameter int         V_ACTIVE = 480,
  parameter logic [2:0] FG_COLOR = 3'b111,
  parameter logic [2:0] BG_COLOR = 3'b000
) (
  input logic                   clk,
  input logic                   rst,
  line_prefetch_buffer_if.slave bus
);
  localparam int WORDS = H_ACTIVE / 16;
  localparam int WCW   = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t           state_reg, state_next;
  logic [WCW-1:0]   word_cnt_reg, word_cnt_next;
  logic [8:0]       rd_row_reg, rd_row_next;
  logic             fill_bank_reg, fill_bank_next;
  logic             pend_valid_reg, pend_valid_next;
  logic [8:0]       pend_row_reg, pend_row_next;
  logic             pend_bank_reg, pend_bank_next;
  logic             second_reg, second_next;   // row-1 fetch still queued after reset
  logic             disp_bank_reg, disp_bank_next;
  logic             underrun_reg, underrun_next;
  logic [2:0]       color_reg;

  logic [15:0]      bank_mem [2][WORDS];
  logic [15:0]      pix_word;
  logic             swap;
  logic             last_word;
  logic [8:0]       swap_row;

  // Last visible pixel of a row ends display of the current bank
  assign swap      = bus.pixelEn & bus.displayActive & (bus.column == 10'(H_ACTIVE - 1));
  assign last_word = (state_reg == FILL) & bus.rdValid & (word_cnt_reg == WCW'(WORDS - 1));
  // Row two ahead of the one just finished, wrapping at the frame bottom
  assign swap_row  = (bus.row >= 9'(V_ACTIVE - 2)) ? (bus.row - 9'(V_ACTIVE - 2))
                                                   : (bus.row + 9'd2);
  assign pix_word  = bank_mem[disp_bank_reg][bus.column[9:4]];

  assign bus.rdReq    = (state_reg == REQ);
  assign bus.rdRow    = rd_row_reg;
  assign bus.fetching = (state_reg != IDLE);
  assign bus.underrun = underrun_reg;
  assign bus.color    = color_reg;

  // Fetch FSM next state, pending-fetch queue and bank swap handling
  always_comb begin
    state_next      = state_reg;
    word_cnt_next   = word_cnt_reg;
    rd_row_next     = rd_row_reg;
    fill_bank_next  = fill_bank_reg;
    pend_valid_next = pend_valid_reg;
    pend_row_next   = pend_row_reg;
    pend_bank_next  = pend_bank_reg;
    second_next     = second_reg;
    disp_bank_next  = disp_bank_reg;
    underrun_next   = underrun_reg;

    case (state_reg)
      IDLE: begin
        // A swap this cycle replaces the pending fetch, so wait one cycle
        if (pend_valid_reg && !swap) begin
          rd_row_next     = pend_row_reg;
          fill_bank_next  = pend_bank_reg;
          pend_valid_next = 1'b0;
          state_next      = REQ;
        end
      end
      REQ: begin
        if (bus.rdAck) begin
          state_next    = FILL;
          word_cnt_next = '0;
        end
      end
      FILL: begin
        if (bus.rdValid) begin
          word_cnt_next = word_cnt_reg + WCW'(1);
          if (last_word) begin
            state_next = IDLE;
            if (second_reg) begin
              pend_valid_next = 1'b1;
              pend_row_next   = 9'd1;
              pend_bank_next  = 1'b1;
              second_next     = 1'b0;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (swap) begin
      disp_bank_next  = ~disp_bank_reg;
      pend_valid_next = 1'b1;
      pend_row_next   = swap_row;
      pend_bank_next  = disp_bank_reg;
      second_next     = 1'b0;
      // Unfinished fetch: abandon it; a completing final word still counts
      if ((state_reg == REQ) || ((state_reg == FILL) && !last_word)) begin
        underrun_next = 1'b1;
        state_next    = IDLE;
      end
    end
  end

  // State registers; reset queues the row-0 then row-1 prefetch
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      word_cnt_reg   <= '0;
      rd_row_reg     <= '0;
      fill_bank_reg  <= 1'b0;
      pend_valid_reg <= 1'b1;
      pend_row_reg   <= '0;
      pend_bank_reg  <= 1'b0;
      second_reg     <= 1'b1;
      disp_bank_reg  <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      word_cnt_reg   <= word_cnt_next;
      rd_row_reg     <= rd_row_next;
      fill_bank_reg  <= fill_bank_next;
      pend_valid_reg <= pend_valid_next;
      pend_row_reg   <= pend_row_next;
      pend_bank_reg  <= pend_bank_next;
      second_reg     <= second_next;
      disp_bank_reg  <= disp_bank_next;
      underrun_reg   <= underrun_next;
    end
  end

  // Bank write port: store each incoming cell word of the active fill
  always_ff @(posedge clk) begin
    if (rst && (state_reg == FILL) && bus.rdValid) begin
      bank_mem[fill_bank_reg][word_cnt_reg] <= bus.rdData;
    end
  end

  // Registered pixel colour, updated once per pixel strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      color_reg <= '0;
    end else if (bus.pixelEn) begin
      if (bus.displayActive) begin
        color_reg <= pix_word[bus.column[3:0]] ? FG_COLOR : BG_COLOR;
      end else begin
        color_reg <= '0;
      end
    end
  end
endmodule

// File: tb/tb_line_prefetch_buffer.sv
// Directed bench for the scanline prefetch buffer: serves fetches, drives
// pixel strobes, and checks colours and fetch rows against its own model.
module tb_line_prefetch_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;

  line_prefetch_buffer_if bus();

  line_prefetch_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_mem [2][40];
  bit          exp_disp = 1'b0;
  int          fq_row[$];
  bit          fq_bank[$];
  logic [2:0]  color_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    exp_disp = 1'b0;
    fq_row.delete();
    fq_bank.delete();
    fq_row.push_back(0);
    fq_bank.push_back(1'b0);
    fq_row.push_back(1);
    fq_bank.push_back(1'b1);
  endtask

  // One pixel strobe; the expected colour is queued and compared one cycle later
  task automatic pixel(input int r, input int c, input bit act);
    logic [15:0] w;
    w = exp_mem[exp_disp][c / 16];
    bus.pixelEn       = 1'b1;
    bus.displayActive = act;
    bus.row           = 9'(r);
    bus.column        = 10'(c);
    color_q.push_back((act && w[c % 16]) ? 3'b111 : 3'b000);
    if (act && c == 639) begin
      fq_row.push_back((r + 2) % 480);
      fq_bank.push_back(exp_disp);
      exp_disp = !exp_disp;
    end
    tick();
    bus.pixelEn       = 1'b0;
    bus.displayActive = 1'b0;
    if (color_q.size() > 0)
      check($sformatf("color r%0d c%0d", r, c), 16'(bus.color), 16'(color_q.pop_front()));
  endtask

  // Serve the next expected fetch: ack after 'latency' cycles, then send words
  task automatic serve(input int nwords, input int latency, input logic [15:0] pat, input bit vary);
    int          exp_row;
    bit          exp_bank;
    int          waited;
    bit          held;
    logic [15:0] d;
    check("fetch_expected", 16'(fq_row.size() > 0), 16'd1);
    if (fq_row.size() == 0) return;
    exp_row  = fq_row.pop_front();
    exp_bank = fq_bank.pop_front();
    waited   = 0;
    while (bus.rdReq !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    check($sformatf("rdReq_seen row%0d", exp_row), 16'(bus.rdReq), 16'd1);
    check($sformatf("rdRow row%0d", exp_row), 16'(bus.rdRow), 16'(exp_row));
    held = 1'b1;
    for (int i = 0; i < latency; i++) begin
      tick();
      if (bus.rdReq !== 1'b1 || bus.rdRow !== 9'(exp_row)) held = 1'b0;
    end
    if (latency > 0) check("rdReq_held", 16'(held), 16'd1);
    bus.rdAck = 1'b1;
    tick();
    bus.rdAck = 1'b0;
    check("rdReq_drop", 16'(bus.rdReq), 16'd0);
    for (int w = 0; w < nwords; w++) begin
      d = vary ? (pat ^ {8'(w), 8'(w)}) : pat;
      bus.rdData  = d;
      bus.rdValid = 1'b1;
      tick();
      if (w < 40) exp_mem[exp_bank][w] = d;
    end
    bus.rdValid = 1'b0;
    if (nwords >= 40) check("fetching_done", 16'(bus.fetching), 16'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pixelEn       = 1'b0;
    bus.displayActive = 1'b0;
    bus.row           = '0;
    bus.column        = '0;
    bus.rdAck         = 1'b0;
    bus.rdData        = '0;
    bus.rdValid       = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int w = 0; w < 40; w++) exp_mem[b][w] = '0;
    reset_model();

    // Reset state
    tick();
    tick();
    check("rst_color",    16'(bus.color),    16'd0);
    check("rst_rdReq",    16'(bus.rdReq),    16'd0);
    check("rst_rdRow",    16'(bus.rdRow),    16'd0);
    check("rst_underrun", 16'(bus.underrun), 16'd0);
    check("rst_fetching", 16'(bus.fetching), 16'd0);
    rst = 1'b1;

    // Initial prefetch: row 0 -> bank 0, row 1 -> bank 1
    serve(40, 2, 16'hAAAA, 1'b0);
    serve(40, 3, 16'h5555, 1'b0);
    check("underrun_init", 16'(bus.underrun), 16'd0);

    // Row 0 from bank 0; blanking forces black; colour holds between strobes
    pixel(0, 0, 1'b1);
    pixel(0, 1, 1'b1);
    pixel(0, 2, 1'b1);
    pixel(0, 3, 1'b1);
    tick();
    check("color_hold", 16'(bus.color), 16'd7);
    pixel(0, 1, 1'b0);
    pixel(0, 321, 1'b1);

    // Swap at end of row 0: row 2 -> bank 0
    pixel(0, 639, 1'b1);
    serve(40, 1, 16'hF00F, 1'b1);
    check("underrun_row2", 16'(bus.underrun), 16'd0);

    // Row 1 from bank 1, then swap at end of row 5: slow ack, 41 words
    pixel(1, 0, 1'b1);
    pixel(1, 1, 1'b1);
    pixel(1, 2, 1'b1);
    pixel(1, 3, 1'b1);
    pixel(5, 639, 1'b1);
    serve(41, 50, 16'h1234, 1'b1);
    check("underrun_row7", 16'(bus.underrun), 16'd0);
    pixel(2, 50, 1'b1);
    pixel(2, 200, 1'b1);
    pixel(2, 615, 1'b1);

    // Swap in the middle of a fill (word 20) raises underrun
    pixel(10, 639, 1'b1);
    serve(20, 2, 16'h3C3C, 1'b1);
    pixel(11, 639, 1'b1);
    check("abort_underrun", 16'(bus.underrun), 16'd1);
    check("abort_rdReq",    16'(bus.rdReq),    16'd0);
    serve(40, 1, 16'h6666, 1'b1);
    check("underrun_sticky1", 16'(bus.underrun), 16'd1);
    pixel(13, 639, 1'b1);
    serve(40, 1, 16'h9999, 1'b0);
    pixel(14, 0, 1'b1);
    pixel(14, 33, 1'b1);
    pixel(14, 200, 1'b1);

    // Frame wrap: rows 478 and 479 fetch rows 0 and 1
    pixel(478, 639, 1'b1);
    serve(40, 1, 16'hFFFF, 1'b0);
    pixel(479, 639, 1'b1);
    serve(40, 1, 16'h8001, 1'b0);
    check("underrun_sticky2", 16'(bus.underrun), 16'd1);
    pixel(0, 5, 1'b1);
    pixel(0, 300, 1'b1);

    // Reset in the middle of a fill restarts the row-0/row-1 prefetch
    pixel(0, 639, 1'b1);
    serve(10, 1, 16'h0000, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    reset_model();
    check("midrst_rdReq",    16'(bus.rdReq),    16'd0);
    check("midrst_color",    16'(bus.color),    16'd0);
    check("midrst_underrun", 16'(bus.underrun), 16'd0);
    check("midrst_fetching", 16'(bus.fetching), 16'd0);
    tick();
    check("restart_rdReq", 16'(bus.rdReq), 16'd1);
    check("restart_rdRow", 16'(bus.rdRow), 16'd0);
    serve(40, 1, 16'h0F0F, 1'b1);
    serve(40, 1, 16'hC3C3, 1'b0);
    pixel(0, 4, 1'b1);
    pixel(0, 19, 1'b1);
    pixel(0, 250, 1'b1);
    check("underrun_final", 16'(bus.underrun), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
